// File: rtl/mem_pkg.sv
// Shared definitions for the IFU/LSU memory arbiter: FSM states, requester
// IDs and the physical memory window decoded by the arbiter.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    localparam logic OWNER_IFU = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

    // Physical memory window; kept wide so MBASE + MSIZE never wraps.
    localparam logic [63:0] MBASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MSIZE = 64'h0000_0000_0800_0000;

    localparam int CNT_W = 4;

    function automatic logic [CNT_W-1:0] wait_count(input int latency);
        if (latency > 0) begin
            return CNT_W'(latency - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant: a sole requester always wins, and on a tie the
// requester that was not granted last time wins.
module rr_arb2
    import mem_pkg::*;
(
    input  logic req_ifu,
    input  logic req_lsu,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_owner
);

    always_comb begin
        gnt_valid = req_ifu | req_lsu;
        gnt_owner = OWNER_IFU;
        if (req_ifu && req_lsu) begin
            gnt_owner = ~last_grant;
        end else if (req_lsu) begin
            gnt_owner = OWNER_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one combinational-read / clocked-write memory port between the IFU
// and LSU, one transaction at a time, with a programmable wait before access.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_LEN   = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [WORD_LEN-1:0]   ifu_rdata,
    output logic                  ifu_resp_err,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [WORD_LEN-1:0]   lsu_wdata,
    input  logic                  lsu_wen,
    input  logic [3:0]            lsu_mask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [WORD_LEN-1:0]   lsu_rdata,
    output logic                  lsu_resp_err,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_LEN-1:0]   mem_wdata,
    output logic                  mem_wen,
    output logic [3:0]            mem_mask,
    input  logic [WORD_LEN-1:0]   mem_rdata
);

    // Handshakes: a request transfers on a rising edge where valid && ready;
    // ready is only ever raised in IDLE. A response transfers on a rising
    // edge where resp_valid && resp_ready; rdata/err are stable meanwhile.

    localparam logic [CNT_W-1:0]    CNT_INIT = wait_count(LATENCY);
    localparam logic [ADDR_WIDTH:0] RANGE_LO = (ADDR_WIDTH+1)'(MBASE);
    localparam logic [ADDR_WIDTH:0] RANGE_HI = (ADDR_WIDTH+1)'(MBASE + MSIZE);

    arb_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_grant_q, last_grant_d;
    logic                  owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_LEN-1:0]   wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic [3:0]            mask_q, mask_d;
    logic [WORD_LEN-1:0]   rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic gnt_valid;
    logic gnt_owner;
    logic in_range;
    logic access_ok;
    logic resp_fire;

    rr_arb2 u_rr_arb2 (
        .req_ifu    (ifu_req_valid),
        .req_lsu    (lsu_req_valid),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

    // Range check one bit wider than the address so the window end cannot wrap.
    assign in_range  = ({1'b0, addr_q} >= RANGE_LO) && ({1'b0, addr_q} < RANGE_HI);
    assign access_ok = in_range && !((owner_q == OWNER_IFU) && (addr_q[1:0] != 2'b00));
    assign resp_fire = (state_q == ST_RESP) &&
                       ((owner_q == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wen_d        = wen_q;
        mask_d       = mask_q;
        rdata_d      = rdata_q;
        err_d        = err_q;

        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is held low while reset is asserted so nothing looks accepted.
                if (reset && gnt_valid) begin
                    ifu_req_ready = (gnt_owner == OWNER_IFU);
                    lsu_req_ready = (gnt_owner == OWNER_LSU);
                    owner_d       = gnt_owner;
                    last_grant_d  = gnt_owner;
                    if (gnt_owner == OWNER_LSU) begin
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wdata;
                        wen_d   = lsu_wen;
                        mask_d  = lsu_mask;
                    end else begin
                        addr_d  = ifu_addr;
                        wdata_d = '0;
                        wen_d   = 1'b0;
                        mask_d  = 4'b0000;
                    end
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACCESS: begin
                rdata_d = (access_ok && !wen_q) ? mem_rdata : '0;
                err_d   = !access_ok;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_fire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wen   = (state_q == ST_ACCESS) && wen_q && in_range;
        mem_mask  = (state_q == ST_ACCESS) ? mask_q : 4'b0000;

        ifu_resp_valid = (state_q == ST_RESP) && (owner_q == OWNER_IFU);
        lsu_resp_valid = (state_q == ST_RESP) && (owner_q == OWNER_LSU);
        ifu_rdata      = ifu_resp_valid ? rdata_q : '0;
        lsu_rdata      = lsu_resp_valid ? rdata_q : '0;
        ifu_resp_err   = ifu_resp_valid && err_q;
        lsu_resp_err   = lsu_resp_valid && err_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            last_grant_q <= OWNER_LSU;
            owner_q      <= OWNER_IFU;
            addr_q       <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            mask_q       <= 4'b0000;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            mask_q       <= mask_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

endmodule
